// File: rtl/memory_stage.sv
// MEM stage of the RV32 pipeline: data-memory handshake with timeout, load/store formatting, MEM/WB register.
// Optional byte access is enabled by defining MEM_BYTE_ACCESS_EN.
module memory_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ByteAddressM,
    input  logic [1:0]  ResultSrcM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic        MemErrW,
    output logic        StallMH,
    output logic [4:0]  RdMH,
    output logic        RegWriteMH
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        w_is_load;
    logic        w_access;
    logic        w_tmo_hit;
    logic        w_tmo_done;
    logic [31:0] w_load_data;

    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_we    = MemWriteM;
    assign RdMH       = RdM;
    assign RegWriteMH = RegWriteM;

    // Request/stall generation; a load that also writes is handled as a store
    always_comb begin
        w_is_load = (ResultSrcM == 2'b01) && !MemWriteM;
        w_access  = MemWriteM || (ResultSrcM == 2'b01);
        w_tmo_hit = (r_state == S_WAIT) && (r_cnt == TMO);
        if (!rst) begin
            dmem_req = 1'b0;
        end else if (r_state == S_WAIT) begin
            dmem_req = 1'b1;
        end else begin
            dmem_req = w_access;
        end
        w_tmo_done = w_tmo_hit && !dmem_ready;
        StallMH    = dmem_req && !dmem_ready && !w_tmo_hit;
    end

`ifdef MEM_BYTE_ACCESS_EN
    // Byte lane steering for stores and byte extraction for loads
    always_comb begin
        dmem_be     = 4'b1111;
        dmem_wdata  = WriteDataM;
        w_load_data = dmem_rdata;
        if (ByteAddressM) begin
            dmem_wdata = {4{WriteDataM[7:0]}};
            case (ALUResultM[1:0])
                2'b00: begin dmem_be = 4'b0001; w_load_data = {24'h000000, dmem_rdata[7:0]};   end
                2'b01: begin dmem_be = 4'b0010; w_load_data = {24'h000000, dmem_rdata[15:8]};  end
                2'b10: begin dmem_be = 4'b0100; w_load_data = {24'h000000, dmem_rdata[23:16]}; end
                2'b11: begin dmem_be = 4'b1000; w_load_data = {24'h000000, dmem_rdata[31:24]}; end
                default: begin dmem_be = 4'b0000; w_load_data = 32'h00000000; end
            endcase
        end else begin
            dmem_be     = 4'b1111;
            dmem_wdata  = WriteDataM;
            w_load_data = dmem_rdata;
        end
    end
`else
    logic w_unused_byte;
    assign w_unused_byte = ByteAddressM;
    assign dmem_be       = 4'b1111;
    assign dmem_wdata    = WriteDataM;
    assign w_load_data   = dmem_rdata;
`endif

    // Access FSM with wait counter; ready wins over timeout in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !dmem_ready) begin
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd1;
                    end else begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready || w_tmo_hit) begin
                        r_state <= S_IDLE;
                        r_cnt   <= 8'd0;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= 8'd0;
                end
            endcase
        end
    end

    // MEM/WB register: stalled edges insert a bubble and hold the data fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUResultW <= 32'h00000000;
            ReadDataW  <= 32'h00000000;
            PCPlus4W   <= 32'h00000000;
            RdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            MemErrW    <= 1'b0;
        end else if (StallMH) begin
            RegWriteW <= 1'b0;
            MemErrW   <= 1'b0;
        end else begin
            ALUResultW <= ALUResultM;
            ReadDataW  <= (w_is_load && !w_tmo_done) ? w_load_data : 32'h00000000;
            PCPlus4W   <= PCPlus4M;
            RdW        <= RdM;
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            MemErrW    <= w_tmo_done;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed self-checking bench for memory_stage (instantiated with TIMEOUT=4).
module tb_memory_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;
    logic        RegWriteM, MemWriteM, ByteAddressM;
    logic [1:0]  ResultSrcM;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdW, RdMH;
    logic        RegWriteW, MemErrW, StallMH, RegWriteMH;
    logic [1:0]  ResultSrcW;

    int errors = 0;
    int checks = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ByteAddressM(ByteAddressM), .ResultSrcM(ResultSrcM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata),
        .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .RdW(RdW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .MemErrW(MemErrW), .StallMH(StallMH), .RdMH(RdMH), .RegWriteMH(RegWriteMH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        ALUResultM = 32'h0; WriteDataM = 32'h0; PCPlus4M = 32'h0; RdM = 5'd0;
        RegWriteM = 1'b0; MemWriteM = 1'b0; ByteAddressM = 1'b0; ResultSrcM = 2'b00;
        dmem_ready = 1'b0; dmem_rdata = 32'h0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [4:0] rd, input logic byte_en);
        set_idle();
        ALUResultM = addr; PCPlus4M = 32'h0000_1004; RdM = rd;
        RegWriteM = 1'b1; ResultSrcM = 2'b01; ByteAddressM = byte_en;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_load(32'h40, 5'd3, 1'b0);
        #2;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", dmem_req); end
        checks++; if (StallMH !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", StallMH); end
        @(posedge clk); #1;
        checks++; if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MemErrW} !== 105'h0) begin
            errors++; $display("FAIL reset_w: W fields not zero, RdW=%h ReadDataW=%h", RdW, ReadDataW); end
        set_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, MemErrW} !== 105'h0) begin
            errors++; $display("FAIL idle_w: W fields not zero after release"); end
        checks++; if (dmem_req !== 1'b0 || StallMH !== 1'b0) begin
            errors++; $display("FAIL idle_req: req=%b stall=%b want 0 0", dmem_req, StallMH); end
    endtask

    task automatic test_word_load();
        set_load(32'h100, 5'd5, 1'b0);
        dmem_ready = 1'b1; dmem_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || StallMH !== 1'b0) begin
            errors++; $display("FAIL wl_hs: req=%b we=%b stall=%b want 1 0 0", dmem_req, dmem_we, StallMH); end
        checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin
            errors++; $display("FAIL wl_addr: addr=%h be=%b want 00000100 1111", dmem_addr, dmem_be); end
        checks++; if (RdMH !== 5'd5 || RegWriteMH !== 1'b1) begin
            errors++; $display("FAIL wl_fwd: RdMH=%0d RegWriteMH=%b want 5 1", RdMH, RegWriteMH); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_data: got %h want deadbeef", ReadDataW); end
        checks++; if (ResultSrcW !== 2'b01 || RdW !== 5'd5 || RegWriteW !== 1'b1 || MemErrW !== 1'b0) begin
            errors++; $display("FAIL wl_ctl: src=%b rd=%0d rw=%b err=%b want 01 5 1 0", ResultSrcW, RdW, RegWriteW, MemErrW); end
        checks++; if (ALUResultW !== 32'h100 || PCPlus4W !== 32'h1004) begin
            errors++; $display("FAIL wl_pass: alu=%h pc4=%h want 100 1004", ALUResultW, PCPlus4W); end
    endtask

    task automatic test_byte_store();
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
`ifdef MEM_BYTE_ACCESS_EN
        exp_be = 4'b1000; exp_wd = 32'h78787878;
`else
        exp_be = 4'b1111; exp_wd = 32'h12345678;
`endif
        set_idle();
        ALUResultM = 32'h203; WriteDataM = 32'h12345678; MemWriteM = 1'b1; ByteAddressM = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF0000;
        #1;
        checks++; if (dmem_be !== exp_be || dmem_wdata !== exp_wd) begin
            errors++; $display("FAIL bs_lane: be=%b wdata=%h want %b %h", dmem_be, dmem_wdata, exp_be, exp_wd); end
        checks++; if (dmem_addr !== 32'h200 || dmem_we !== 1'b1 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL bs_hs: addr=%h we=%b req=%b want 200 1 1", dmem_addr, dmem_we, dmem_req); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'h0 || RegWriteW !== 1'b0) begin
            errors++; $display("FAIL bs_w: ReadDataW=%h RegWriteW=%b want 0 0", ReadDataW, RegWriteW); end
    endtask

    task automatic test_byte_load();
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
`ifdef MEM_BYTE_ACCESS_EN
        exp_rd = 32'h000000CC; exp_be = 4'b0010;
`else
        exp_rd = 32'hAABBCCDD; exp_be = 4'b1111;
`endif
        set_load(32'h201, 5'd7, 1'b1);
        dmem_ready = 1'b1; dmem_rdata = 32'hAABBCCDD;
        #1;
        checks++; if (dmem_be !== exp_be || dmem_addr !== 32'h200) begin
            errors++; $display("FAIL bl_be: be=%b addr=%h want %b 200", dmem_be, dmem_addr, exp_be); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== exp_rd) begin errors++; $display("FAIL bl_data: got %h want %h", ReadDataW, exp_rd); end
    endtask

    task automatic test_wait_load();
        set_load(32'h404, 5'd11, 1'b0);
        dmem_rdata = 32'h99999999;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (StallMH !== 1'b1 || dmem_req !== 1'b1) begin
                errors++; $display("FAIL wait_stall%0d: stall=%b req=%b want 1 1", i, StallMH, dmem_req); end
            @(posedge clk); #1;
            checks++; if (RegWriteW !== 1'b0 || MemErrW !== 1'b0) begin
                errors++; $display("FAIL wait_bubble%0d: RegWriteW=%b MemErrW=%b want 0 0", i, RegWriteW, MemErrW); end
        end
        dmem_ready = 1'b1; dmem_rdata = 32'h13572468;
        #1;
        checks++; if (StallMH !== 1'b0 || dmem_req !== 1'b1) begin
            errors++; $display("FAIL wait_done: stall=%b req=%b want 0 1", StallMH, dmem_req); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'h13572468 || RegWriteW !== 1'b1 || RdW !== 5'd11) begin
            errors++; $display("FAIL wait_data: data=%h rw=%b rd=%0d want 13572468 1 11", ReadDataW, RegWriteW, RdW); end
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int stall_cnt = 0;
        set_load(32'h500, 5'd13, 1'b0);
        dmem_rdata = 32'h5A5A5A5A;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (dmem_req === 1'b1) req_cnt++;
            if (StallMH === 1'b1) stall_cnt++;
            @(posedge clk); #1;
            if (i < 4) begin
                checks++; if (RegWriteW !== 1'b0 || MemErrW !== 1'b0) begin
                    errors++; $display("FAIL tmo_bubble%0d: rw=%b err=%b want 0 0", i, RegWriteW, MemErrW); end
            end else begin
                checks++; if (MemErrW !== 1'b1 || ReadDataW !== 32'h0 || RegWriteW !== 1'b1) begin
                    errors++; $display("FAIL tmo_done: err=%b data=%h rw=%b want 1 0 1", MemErrW, ReadDataW, RegWriteW); end
            end
        end
        checks++; if (req_cnt !== 5 || stall_cnt !== 4) begin
            errors++; $display("FAIL tmo_counts: req=%0d stall=%0d want 5 4", req_cnt, stall_cnt); end
        set_idle();
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL tmo_req_drop: got %b want 0", dmem_req); end
        @(posedge clk); #1;
        checks++; if (MemErrW !== 1'b0) begin errors++; $display("FAIL tmo_err_pulse: got %b want 0", MemErrW); end
    endtask

    task automatic test_reset_in_wait();
        set_load(32'h600, 5'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || RegWriteW !== 1'b0 || RdW !== 5'd0) begin
            errors++; $display("FAIL rstw_drop: req=%b rw=%b rd=%0d want 0 0 0", dmem_req, RegWriteW, RdW); end
        set_idle();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0 || StallMH !== 1'b0) begin
            errors++; $display("FAIL rstw_idle: req=%b stall=%b want 0 0", dmem_req, StallMH); end
        @(posedge clk); #1;
    endtask

    task automatic test_ready_no_req();
        set_idle();
        dmem_ready = 1'b1; dmem_rdata = 32'h77777777;
        #1;
        checks++; if (dmem_req !== 1'b0 || StallMH !== 1'b0) begin
            errors++; $display("FAIL stray_ready: req=%b stall=%b want 0 0", dmem_req, StallMH); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'h0 || MemErrW !== 1'b0) begin
            errors++; $display("FAIL stray_w: data=%h err=%b want 0 0", ReadDataW, MemErrW); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        ALUResultM = 32'h300; WriteDataM = 32'hCAFEF00D; MemWriteM = 1'b1; dmem_ready = 1'b1;
        #1;
        checks++; if (dmem_we !== 1'b1 || dmem_wdata !== 32'hCAFEF00D || StallMH !== 1'b0) begin
            errors++; $display("FAIL b2b_store: we=%b wdata=%h stall=%b want 1 cafef00d 0", dmem_we, dmem_wdata, StallMH); end
        @(posedge clk); #1;
        checks++; if (ALUResultW !== 32'h300 || ReadDataW !== 32'h0) begin
            errors++; $display("FAIL b2b_store_w: alu=%h data=%h want 300 0", ALUResultW, ReadDataW); end
        set_load(32'h304, 5'd9, 1'b0);
        dmem_ready = 1'b1; dmem_rdata = 32'h0BADF00D;
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || StallMH !== 1'b0) begin
            errors++; $display("FAIL b2b_load: req=%b we=%b stall=%b want 1 0 0", dmem_req, dmem_we, StallMH); end
        @(posedge clk); #1;
        checks++; if (ReadDataW !== 32'h0BADF00D || RdW !== 5'd9) begin
            errors++; $display("FAIL b2b_load_w: data=%h rd=%0d want 0badf00d 9", ReadDataW, RdW); end
    endtask

    initial begin
        test_reset();
        test_word_load();
        test_byte_store();
        test_byte_load();
        test_wait_load();
        test_timeout();
        test_reset_in_wait();
        test_ready_no_req();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the five-stage RV32 core, directly downstream of the execute stage. It consumes the EX/MEM register outputs and drives a single-port data-memory request/ready handshake. It performs word and byte load/store formatting and stalls the pipeline while memory is busy. It holds the MEM/WB pipeline register and feeds the writeback mux and the hazard unit.

## Interface
- `TIMEOUT`, 15: maximum wait cycles per access before forced completion with error (1..255).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `ALUResultM`  in  32  memory address, or result forwarded for non-memory ops.
- `WriteDataM`  in  32  store data.
- `PCPlus4M`  in  32  link value.
- `RdM`  in  5  destination register.
- `RegWriteM`, `MemWriteM`, `ByteAddressM`  in  1 each  control bits.
- `ResultSrcM`  in  2  writeback select; 2'b01 = load.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  write when high.
- `dmem_addr`  out  32  word-aligned address `{ALUResultM[31:2],2'b00}`.
- `dmem_wdata`  out  32  store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ready`  in  1  access complete this cycle.
- `dmem_rdata`  in  32  read data, valid when `dmem_ready` is high.
- `ALUResultW`, `ReadDataW`, `PCPlus4W`  out  32 each  MEM/WB register.
- `RdW`  out  5  MEM/WB register.
- `RegWriteW`  out  1  MEM/WB register.
- `ResultSrcW`  out  2  MEM/WB register.
- `MemErrW`  out  1  access in W ended by timeout.
- `StallMH`  out  1  to hazard unit: freeze PC, IF/ID, ID/EX and EX/MEM.
- `RdMH`, `RegWriteMH`  out  5/1  pass-through of `RdM`/`RegWriteM` for forwarding.

## Operation
- access = `MemWriteM` | (`ResultSrcM`==2'b01). A load with `MemWriteM`=1 is treated as a store.
- FSM states:
  - IDLE. access & `dmem_ready` -> stay IDLE. access & !ready -> WAIT, cnt<=1. No access -> IDLE.
  - WAIT. ready -> IDLE, cnt<=0. cnt==`TIMEOUT` -> IDLE, timeout completion. Otherwise cnt<=cnt+1.
- `dmem_req` = access in IDLE, or state==WAIT. It is combinational, and is deasserted in the completing cycle only after that edge.
- `StallMH` = `dmem_req` & !`dmem_ready` & !(WAIT & cnt==`TIMEOUT`).
- Word access: `dmem_be`=4'b1111; `dmem_wdata`=`WriteDataM`; load data = `dmem_rdata`.
- `dmem_we`=`MemWriteM`. `dmem_be` and `dmem_wdata` are don't-care for loads, but are driven as for stores.
- MEM/WB capture on every unstalled edge:
  - `ALUResultW`, `PCPlus4W`, `RdW` and `ResultSrcW` copy their M inputs.
  - `ReadDataW` = formatted load data, or 0 on timeout or non-load.
  - `MemErrW` = timeout completion.
- While `StallMH`=1, W captures a bubble: `RegWriteW`=0 and `MemErrW`=0. All other W fields hold.

## Timing
- Reset (async, `rst`=0): FSM IDLE, cnt=0. All W outputs are 0. `dmem_req`=0 while reset is low, regardless of inputs.
- Reset asserted mid-WAIT aborts the access immediately with no completion. The memory side must tolerate a dropped request.
- Zero-wait memory (ready in the request cycle): M->W latency is 1 cycle and there are no stall cycles.
- N-cycle memory: `StallMH` is high for N cycles and W receives N bubbles. The access completes on the edge closing the cycle in which ready is seen.
- Timeout: the request is asserted for `TIMEOUT`+1 cycles. On the last of these, `StallMH`=0, and W gets `MemErrW`=1, `ReadDataW`=0 and `RegWriteW`=`RegWriteM`.
- `dmem_ready` asserted with no request is ignored.
- Back-to-back accesses are allowed: the next access issues in the cycle after completion with no idle gap.

## Configuration
- `MEM_BYTE_ACCESS_EN` defined: `ByteAddressM`=1 selects byte access, with b=`ALUResultM[1:0]`.
  - Store: `dmem_be`=4'b0001<<b, `dmem_wdata`=`{4{WriteDataM[7:0]}}`.
  - Load: `ReadDataW`=zero-extended `dmem_rdata[8b+7:8b]`.
- Undefined: `ByteAddressM` is ignored, all accesses are word accesses, and `ALUResultM[1:0]` is ignored.

## Test plan
- Reset then release, no access -> all W outputs 0, `dmem_req`=0, `StallMH`=0.
- Word load, addr 0x100, ready in the same cycle, rdata 0xDEADBEEF -> no stall; next cycle `ReadDataW`=0xDEADBEEF, `ResultSrcW`=01, `RdW`=`RdM`.
- Byte store, addr 0x203, data 0x12345678, `MEM_BYTE_ACCESS_EN` defined -> `dmem_be`=1000, `dmem_wdata`=0x78787878, `dmem_addr`=0x200.
- Byte load, addr 0x201, rdata 0xAABBCCDD -> `ReadDataW`=0x000000CC. With the macro undefined -> 0xAABBCCDD and `dmem_be`=1111.
- Word load with ready after 3 wait cycles -> `StallMH` high 3 cycles, 3 W bubbles (`RegWriteW`=0), then the correct data. A reset pulse injected during WAIT -> `dmem_req` drops immediately and FSM returns to IDLE.
- `TIMEOUT`=4, ready never asserted -> `dmem_req` high 5 cycles, `StallMH` high 4, then `MemErrW`=1 and `ReadDataW`=0 for one cycle.
